// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch sequencer states, redirect kinds and
// instruction geometry.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    BR   = 2'd1,
    J    = 2'd2,
    JR   = 2'd3
  } redirect_kind_e;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/branch_target_gen.sv
// Combinational redirect target former: priority jr > jump > branch, with
// word alignment of offsets and the jr misalignment flag.
module branch_target_gen
  import cpu_pkg::*;
(
  input  logic        jr_i,
  input  logic        jump_i,
  input  logic        branch_i,
  input  logic [31:0] jr_addr_i,
  input  logic [31:0] link_pc4_i,
  input  logic [31:0] branch_imm_i,
  input  logic [25:0] jump_idx_i,
  output logic [31:0] target_o,
  output logic        redirect_o,
  output logic        addr_err_o
);

  redirect_kind_e kind;

  always_comb begin
    kind = NONE;
    if (jr_i)          kind = JR;
    else if (jump_i)   kind = J;
    else if (branch_i) kind = BR;
  end

  // Branch offsets are in words; the carry out of the add is dropped.
  always_comb begin
    target_o = 32'h0;
    case (kind)
      JR:      target_o = {jr_addr_i[31:2], 2'b00};
      J:       target_o = {link_pc4_i[31:28], jump_idx_i, 2'b00};
      BR:      target_o = link_pc4_i + {branch_imm_i[29:0], 2'b00};
      default: target_o = 32'h0;
    endcase
  end

  assign redirect_o = (kind != NONE);
  assign addr_err_o = jr_i & (|jr_addr_i[1:0]);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: issues ready-handshaked fetches,
// applies stalls, resolves redirects and counts fetch wait cycles.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  input  logic             imem_ready_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic [31:0]      branch_imm_i,
  input  logic [31:0]      link_pc4_i,
  input  logic             jump_i,
  input  logic [25:0]      jump_idx_i,
  input  logic             jr_i,
  input  logic [31:0]      jr_addr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic             instr_valid_o,
  output logic             flush_o,
  output logic             addr_err_o,
  output logic [CNT_W-1:0] wait_cnt_o,
  output pc_state_e        state_o
);

  // Handshake: a request is held (address stable) while imem_req_o=1 and
  // imem_ready_i=0; the cycle with both high completes it.

  pc_state_e        state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic [31:0] target;
  logic        redirect;
  logic        addr_err;

  branch_target_gen u_btg (
    .jr_i         (jr_i),
    .jump_i       (jump_i),
    .branch_i     (branch_i),
    .jr_addr_i    (jr_addr_i),
    .link_pc4_i   (link_pc4_i),
    .branch_imm_i (branch_imm_i),
    .jump_idx_i   (jump_idx_i),
    .target_o     (target),
    .redirect_o   (redirect),
    .addr_err_o   (addr_err)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pend_pc_q  <= 32'h0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (!imem_ready_i && redirect) state_d = DRAIN;
      DRAIN:   if (imem_ready_i) state_d = FETCH;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    case (state_q)
      BOOT: if (redirect) pc_d = target;
      FETCH: begin
        if (imem_ready_i) begin
          if (redirect)      pc_d = target;
          else if (!stall_i) pc_d = pc_q + INSTR_BYTES;
        end else if (redirect) begin
          pend_pc_d = target;
        end
      end
      DRAIN: begin
        if (redirect) pend_pc_d = target;
        // The drained response is thrown away; a same-cycle redirect wins.
        if (imem_ready_i) pc_d = redirect ? target : pend_pc_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    imem_req_o    = (state_q != BOOT);
    instr_valid_o = (state_q == FETCH) && imem_ready_i && !redirect && !stall_i;
    flush_o       = redirect && !rst_i;
    addr_err_o    = addr_err && !rst_i;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (imem_req_o && !imem_ready_i && (wait_cnt_q != {CNT_W{1'b1}}))
      wait_cnt_d = wait_cnt_q + 1'b1;
  end

  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign pc_plus4_o  = pc_q + INSTR_BYTES;
  assign wait_cnt_o  = wait_cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: per-cycle expectations plus a queue of
// expected accepted-fetch addresses.
module tb_pc_sequencer;
  import cpu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_imm_i;
  logic [31:0] link_pc4_i;
  logic        jump_i;
  logic [25:0] jump_idx_i;
  logic        jr_i;
  logic [31:0] jr_addr_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        instr_valid_o;
  logic        flush_o;
  logic        addr_err_o;
  logic [31:0] wait_cnt_o;
  pc_state_e   state_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_wait = 32'd0;

  pc_sequencer #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .stall_i       (stall_i),
    .branch_i      (branch_i),
    .branch_imm_i  (branch_imm_i),
    .link_pc4_i    (link_pc4_i),
    .jump_i        (jump_i),
    .jump_idx_i    (jump_idx_i),
    .jr_i          (jr_i),
    .jr_addr_i     (jr_addr_i),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .instr_valid_o (instr_valid_o),
    .flush_o       (flush_o),
    .addr_err_o    (addr_err_o),
    .wait_cnt_o    (wait_cnt_o),
    .state_o       (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic rdy, input logic stl, input logic br,
                        input logic jp, input logic jrr);
    imem_ready_i = rdy;
    stall_i      = stl;
    branch_i     = br;
    jump_i       = jp;
    jr_i         = jrr;
  endtask

  // Called at posedge+1 after inputs are set; compares at the negedge and
  // returns at the next posedge+1.
  task automatic step(input string tag, input logic e_req, input logic [31:0] e_addr,
                      input logic e_valid, input logic e_flush, input logic e_err);
    logic [31:0] got;
    if (e_valid) exp_q.push_back(e_addr);
    @(negedge clk_i);
    chk({tag, ".req"},   {31'd0, imem_req_o},    {31'd0, e_req});
    chk({tag, ".addr"},  imem_addr_o,            e_addr);
    chk({tag, ".pc"},    pc_o,                   e_addr);
    chk({tag, ".pc4"},   pc_plus4_o,             e_addr + 32'd4);
    chk({tag, ".valid"}, {31'd0, instr_valid_o}, {31'd0, e_valid});
    chk({tag, ".flush"}, {31'd0, flush_o},       {31'd0, e_flush});
    chk({tag, ".err"},   {31'd0, addr_err_o},    {31'd0, e_err});
    chk({tag, ".wait"},  wait_cnt_o,             exp_wait);
    if (instr_valid_o) begin
      if (exp_q.size() == 0) begin
        chk({tag, ".sb_unexpected"}, imem_addr_o, 32'hDEAD_BEEF);
      end else begin
        got = exp_q.pop_front();
        chk({tag, ".sb_addr"}, imem_addr_o, got);
      end
    end
    if (e_req && !imem_ready_i && exp_wait != 32'hFFFF_FFFF) exp_wait++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".req"},   {31'd0, imem_req_o},    32'd0);
    chk({tag, ".valid"}, {31'd0, instr_valid_o}, 32'd0);
    chk({tag, ".flush"}, {31'd0, flush_o},       32'd0);
    chk({tag, ".err"},   {31'd0, addr_err_o},    32'd0);
    chk({tag, ".wait"},  wait_cnt_o,             32'd0);
    chk({tag, ".pc"},    pc_o,                   32'h0);
    chk({tag, ".addr"},  imem_addr_o,            32'h0);
  endtask

  initial begin
    rst_i        = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    branch_imm_i = 32'h0;
    link_pc4_i   = 32'h0;
    jump_idx_i   = 26'h0;
    jr_addr_i    = 32'h0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_reset("rst0");

    // Boot cycle then back-to-back fetches with ready tied high.
    rst_i = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("boot", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step("f0",   1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
    step("f4",   1'b1, 32'h4, 1'b1, 1'b0, 1'b0);
    step("f8",   1'b1, 32'h8, 1'b1, 1'b0, 1'b0);

    // Jump to 0x100 with ready=1.
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    jump_idx_i = 26'h40; link_pc4_i = 32'h10;
    step("j100", 1'b1, 32'hC, 1'b0, 1'b1, 1'b0);

    // Backward branch: 0x104 + (-2 words) = 0xFC.
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    branch_imm_i = 32'hFFFF_FFFE; link_pc4_i = 32'h104;
    step("br_fc", 1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("at_fc", 1'b1, 32'hFC, 1'b1, 1'b0, 1'b0);

    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    jump_idx_i = 26'h80; link_pc4_i = 32'h104;
    step("j200", 1'b1, 32'h100, 1'b0, 1'b1, 1'b0);

    // Jump while the fetch at 0x200 is still outstanding.
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("w200", 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    jump_idx_i = 26'h40; link_pc4_i = 32'h204;
    step("j_pend", 1'b1, 32'h200, 1'b0, 1'b1, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("drain_w", 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("drain_rdy", 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    step("at_100", 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);

    // Branch to 0x300 while waiting, then misaligned jr overrides in DRAIN.
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    link_pc4_i = 32'h108; branch_imm_i = 32'h7E;
    step("br300_pend", 1'b1, 32'h104, 1'b0, 1'b1, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    jr_addr_i = 32'h403;
    step("jr_drain", 1'b1, 32'h104, 1'b0, 1'b1, 1'b1);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("drain2_rdy", 1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
    step("at_400", 1'b1, 32'h400, 1'b1, 1'b0, 1'b0);

    // Three stalled cycles re-request the same address.
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("stall", 1'b1, 32'h404, 1'b0, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("unstall0", 1'b1, 32'h404, 1'b1, 1'b0, 1'b0);
    step("unstall1", 1'b1, 32'h408, 1'b1, 1'b0, 1'b0);

    // Redirect beats a simultaneous stall.
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    jr_addr_i = 32'h500;
    step("stall_jr", 1'b1, 32'h40C, 1'b0, 1'b1, 1'b0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("at_500", 1'b1, 32'h500, 1'b1, 1'b0, 1'b0);

    // PC+4 wraps past the top of the address space.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    jr_addr_i = 32'hFFFF_FFFC;
    step("jr_top", 1'b1, 32'h504, 1'b0, 1'b1, 1'b0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("at_top", 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);

    // Five wait cycles, then reset lands mid-request.
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("wait5", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("wait_total", wait_cnt_o, 32'd10);
    branch_i = 1'b1;
    jr_i     = 1'b1;
    jr_addr_i = 32'h7;
    rst_i = 1'b1;
    #1;
    chk_reset("rst_mid");
    exp_wait = 32'd0;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk_i);
    #1;
    chk_reset("rst_hold");
    rst_i = 1'b0;
    step("boot2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step("f0_2",  1'b1, 32'h0, 1'b1, 1'b0, 1'b0);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
